// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage feeding the decode stage.
//
// Owns the PC, issues requests to a variable-latency instruction memory and
// drives the IF/ID pipeline register (pc_4, instruction) read by decode.
// Honours decode's load-use stall (shouldStall) and its jump/branch redirect.
// Inserts NOP bubbles while memory is busy and remembers a redirect that
// arrives while a fetch is still outstanding.
//
// Ports:
//   clock, reset                  stage clock; asynchronous active-high reset
//   shouldStall                   freeze PC and IF/ID
//   shouldJumpOrBranch            redirect request for the instruction in IF/ID
//   jumpOrBranchPc[31:0]          redirect target
//   instructionMemoryRequest      fetch request valid
//   instructionMemoryAddress      fetch address (the PC)
//   instructionMemoryReady        fetch completes this cycle
//   instructionMemoryData[31:0]   fetched word, valid with ready
//   pc_4[31:0], instruction[31:0] IF/ID register
//   debug_pc[31:0]                current PC register
//
// Build option:
//   IF_STAGE_FLUSH_DELAY_SLOT_EN  when defined, the completion that consumes a
//                                 redirect loads a NOP instead of the fetched
//                                 word, removing the architectural delay slot.
//                                 Undefined: MIPS delay-slot semantics.
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        shouldStall,
    input  logic        shouldJumpOrBranch,
    input  logic [31:0] jumpOrBranchPc,
    output logic        instructionMemoryRequest,
    output logic [31:0] instructionMemoryAddress,
    input  logic        instructionMemoryReady,
    input  logic [31:0] instructionMemoryData,
    output logic [31:0] pc_4,
    output logic [31:0] instruction,
    output logic [31:0] debug_pc
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetchState_t;

    fetchState_t stateReg, stateNext;
    logic [31:0] pcReg, pcNext;
    logic [31:0] pc4Reg, pc4Next;
    logic [31:0] instructionReg, instructionNext;
    logic        redirectPendingReg, redirectPendingNext;
    logic [31:0] redirectTargetReg, redirectTargetNext;
    logic [31:0] holdBufferReg, holdBufferNext;

    logic        completion;
    logic [31:0] fetchedWord;
    logic [31:0] pcPlus4;

    // A word is available either straight from memory or from the hold buffer
    // (captured earlier while decode was stalling).
    assign completion  = ((stateReg == FETCH) && instructionMemoryReady) || (stateReg == HOLD);
    assign fetchedWord = (stateReg == HOLD) ? holdBufferReg : instructionMemoryData;
    assign pcPlus4     = pcReg + 32'd4;

`ifdef IF_STAGE_FLUSH_DELAY_SLOT_EN
    logic takeRedirect;
    assign takeRedirect = shouldJumpOrBranch || redirectPendingReg;
`endif

    always_comb begin
        stateNext           = stateReg;
        pcNext              = pcReg;
        pc4Next             = pc4Reg;
        instructionNext     = instructionReg;
        redirectPendingNext = redirectPendingReg;
        redirectTargetNext  = redirectTargetReg;
        holdBufferNext      = holdBufferReg;

        if (completion && !shouldStall) begin
            pc4Next         = pcPlus4;
            instructionNext = fetchedWord;
`ifdef IF_STAGE_FLUSH_DELAY_SLOT_EN
            if (takeRedirect) begin
                instructionNext = NOP_INSTRUCTION;
            end
`endif
            // A fresh redirect from decode beats a remembered one.
            if (shouldJumpOrBranch) begin
                pcNext = jumpOrBranchPc;
            end else if (redirectPendingReg) begin
                pcNext = redirectTargetReg;
            end else begin
                pcNext = pcPlus4;
            end
            redirectPendingNext = 1'b0;
            stateNext           = FETCH;
        end else if (completion) begin
            // Stalled with a word in hand: park it so it is never refetched.
            if (stateReg == FETCH) begin
                holdBufferNext = instructionMemoryData;
                stateNext      = HOLD;
            end
        end else if (!shouldStall) begin
            // Memory busy: bubble into decode. A branch leaving decode now has
            // its delay slot as the outstanding fetch, so remember the target.
            instructionNext = NOP_INSTRUCTION;
            if (shouldJumpOrBranch) begin
                redirectPendingNext = 1'b1;
                redirectTargetNext  = jumpOrBranchPc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg           <= FETCH;
            pcReg              <= RESET_PC;
            pc4Reg             <= 32'd0;
            instructionReg     <= NOP_INSTRUCTION;
            redirectPendingReg <= 1'b0;
            redirectTargetReg  <= 32'd0;
            holdBufferReg      <= 32'd0;
        end else begin
            stateReg           <= stateNext;
            pcReg              <= pcNext;
            pc4Reg             <= pc4Next;
            instructionReg     <= instructionNext;
            redirectPendingReg <= redirectPendingNext;
            redirectTargetReg  <= redirectTargetNext;
            holdBufferReg      <= holdBufferNext;
        end
    end

    // Request drops the instant reset rises, not at the next edge.
    assign instructionMemoryRequest = (stateReg == FETCH) && !reset;
    assign instructionMemoryAddress = pcReg;
    assign pc_4                     = pc4Reg;
    assign instruction              = instructionReg;
    assign debug_pc                 = pcReg;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// Memory returns mem[a] = a when ready and random junk otherwise. A reference
// model tracks the stage at the level of "PC, IF/ID contents, whether the word
// for the current PC has already been obtained, pending redirect".
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
`ifdef IF_STAGE_FLUSH_DELAY_SLOT_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        shouldStall;
    logic        shouldJumpOrBranch;
    logic [31:0] jumpOrBranchPc;
    logic        instructionMemoryRequest;
    logic [31:0] instructionMemoryAddress;
    logic        instructionMemoryReady;
    logic [31:0] instructionMemoryData;
    logic [31:0] pc_4;
    logic [31:0] instruction;
    logic [31:0] debug_pc;
    logic [31:0] junk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic [31:0] mPc, mPc4, mInstr, mTarget;
    bit          mPending, mCaptured;

    always #5 clock = ~clock;

    assign instructionMemoryData = instructionMemoryReady ? instructionMemoryAddress : junk;

    if_stage #(
        .RESET_PC       (RESET_PC),
        .NOP_INSTRUCTION(NOP)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .shouldStall             (shouldStall),
        .shouldJumpOrBranch      (shouldJumpOrBranch),
        .jumpOrBranchPc          (jumpOrBranchPc),
        .instructionMemoryRequest(instructionMemoryRequest),
        .instructionMemoryAddress(instructionMemoryAddress),
        .instructionMemoryReady  (instructionMemoryReady),
        .instructionMemoryData   (instructionMemoryData),
        .pc_4                    (pc_4),
        .instruction             (instruction),
        .debug_pc                (debug_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPc       = RESET_PC;
        mPc4      = 32'd0;
        mInstr    = NOP;
        mPending  = 1'b0;
        mTarget   = 32'd0;
        mCaptured = 1'b0;
    endtask

    // One clock of stimulus: drive, check fetch outputs mid-cycle, clock,
    // advance the model, then check the IF/ID register and PC.
    task automatic cycle(input bit rdy, input bit stl, input bit jb, input logic [31:0] tgt);
        bit got, redirect;
        instructionMemoryReady = rdy;
        shouldStall            = stl;
        shouldJumpOrBranch     = jb;
        jumpOrBranchPc         = tgt;
        junk                   = $urandom;
        #4;
        check("request", {31'd0, instructionMemoryRequest}, {31'd0, !mCaptured});
        if (!mCaptured) check("address", instructionMemoryAddress, mPc);
        @(posedge clock);
        got      = mCaptured || rdy;
        redirect = jb || mPending;
        if (got && !stl) begin
            mInstr    = (FLUSH && redirect) ? NOP : mPc;   // mem[a] = a
            mPc4      = mPc + 32'd4;
            mPc       = jb ? tgt : (mPending ? mTarget : mPc + 32'd4);
            mPending  = 1'b0;
            mCaptured = 1'b0;
        end else if (got) begin
            mCaptured = 1'b1;
        end else if (!stl) begin
            mInstr = NOP;
            if (jb) begin
                mPending = 1'b1;
                mTarget  = tgt;
            end
        end
        #1;
        cyc++;
        $display("cyc %0d rdy=%0b stl=%0b jb=%0b tgt=%h -> pc=%h ifid=%h/%h",
                 cyc, rdy, stl, jb, tgt, debug_pc, pc_4, instruction);
        check("pc_4", pc_4, mPc4);
        check("instruction", instruction, mInstr);
        check("debug_pc", debug_pc, mPc);
    endtask

    task automatic checkIfid(input string tag, input logic [31:0] expPc4, input logic [31:0] expInstr);
        check({tag, "_pc4"}, pc_4, expPc4);
        check({tag, "_instr"}, instruction, expInstr);
    endtask

    initial begin
        reset                  = 1'b1;
        shouldStall            = 1'b0;
        shouldJumpOrBranch     = 1'b0;
        jumpOrBranchPc         = 32'd0;
        instructionMemoryReady = 1'b0;
        junk                   = 32'hDEAD_BEEF;
        modelReset();

        // Reset state
        #3;
        check("rst_request", {31'd0, instructionMemoryRequest}, 32'd0);
        check("rst_instr", instruction, NOP);
        check("rst_pc4", pc_4, 32'd0);
        check("rst_pc", debug_pc, RESET_PC);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // 1: streaming, one instruction per cycle
        cycle(1, 0, 0, 0);
        checkIfid("t1a", 32'h4, 32'h0);
        cycle(1, 0, 0, 0);
        checkIfid("t1b", 32'h8, 32'h4);

        // 2: memory busy 3 cycles at 0x8
        repeat (3) begin
            cycle(0, 0, 0, 0);
            check("t2_bubble", instruction, NOP);
            check("t2_addr", instructionMemoryAddress, 32'h8);
        end
        cycle(1, 0, 0, 0);
        checkIfid("t2", 32'hC, 32'h8);

        // 3: stall two cycles with data ready, release with memory idle
        cycle(1, 1, 0, 0);
        checkIfid("t3_frozen", 32'hC, 32'h8);
        check("t3_req_low", {31'd0, instructionMemoryRequest}, 32'd0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);
        checkIfid("t3", 32'h10, 32'hC);

        // 4: branch to 0x40 while fetching 0x14 with memory ready
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 32'h40);
        checkIfid("t4_slot", 32'h18, FLUSH ? NOP : 32'h14);
        cycle(1, 0, 0, 0);
        checkIfid("t4_tgt", 32'h44, 32'h40);
        cycle(1, 0, 0, 0);
        checkIfid("t4_next", 32'h48, 32'h44);

        // 5: branch while memory busy (fetching 0x48)
        cycle(0, 0, 1, 32'h100);
        cycle(0, 0, 0, 0);
        check("t5_bubble", instruction, NOP);
        cycle(1, 0, 0, 0);
        checkIfid("t5_slot", 32'h4C, FLUSH ? NOP : 32'h48);
        cycle(1, 0, 0, 0);
        checkIfid("t5_tgt", 32'h104, 32'h100);

        // PC wrap at the top of the address space
        cycle(1, 0, 1, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 0);
        checkIfid("wrap", 32'h0000_0000, 32'hFFFF_FFFC);
        check("wrap_pc", debug_pc, 32'h0000_0000);

        // 6: reset mid-fetch with a redirect pending
        cycle(0, 0, 1, 32'h200);
        instructionMemoryReady = 1'b0;
        shouldJumpOrBranch     = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t6_request", {31'd0, instructionMemoryRequest}, 32'd0);
        check("t6_instr", instruction, NOP);
        check("t6_pc4", pc_4, 32'd0);
        check("t6_pc", debug_pc, RESET_PC);
        @(posedge clock);
        #1;
        reset = 1'b0;
        modelReset();
        cycle(1, 0, 0, 0);
        checkIfid("t6_restart", RESET_PC + 32'd4, RESET_PC);
        check("t6_no_pending", debug_pc, RESET_PC + 32'd4);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit          rdy, stl, jb;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 3) != 0);
            stl = ($urandom_range(0, 4) == 0);
            jb  = !mPending && ($urandom_range(0, 5) == 0);
            tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            cycle(rdy, stl, jb, tgt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
